// File: rtl/data_mem.sv
// data_mem: byte-addressable RV32I data memory over a DEPTH x 32 little-endian array.
// Byte/half/word loads and stores; accesses that spill past the end of a word are
// split into two beats (IDLE -> SECOND) behind a valid/ready request handshake.
module data_mem #(
    parameter int    ADDR_WIDTH = 32,
    parameter int    DEPTH      = 1024,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic                  rsp_valid,
    output logic [31:0]           read_data
);
    localparam int IDX = $clog2(DEPTH);

    typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

    logic [31:0] mem [DEPTH];

    state_t         state_q;
    logic           rsp_valid_q;
    logic [31:0]    read_data_q;
    // Request context carried from the first beat into SECOND.
    logic [IDX-1:0] idx2_q;
    logic [1:0]     off_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic           we_q;
    logic [3:0]     be2_q;
    logic [31:0]    wd2_q;
    logic [31:0]    first_q;

    logic [IDX-1:0] idx;
    logic [IDX-1:0] idx2_d;
    logic [1:0]     off;
    logic [3:0]     nmask;
    logic [7:0]     lane_mask;
    logic [63:0]    wd_shift;
    logic           crossing;
    logic           accept;
    logic [IDX-1:0] rd_idx;
    logic [31:0]    rd_word;
    logic [31:0]    single_raw;
    logic [63:0]    cross_window;
    logic [IDX-1:0] wr_idx;
    logic [3:0]     wr_be;
    logic [31:0]    wr_data;

    assign idx    = address[IDX+1:2];
    assign idx2_d = idx + IDX'(1);
    assign off    = address[1:0];

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign read_data = read_data_q;

    // A request arriving together with reset is not taken.
    assign accept = req_valid & req_ready & ~rst;

    // Lane mask across an 8-byte window (this word + next); upper nibble set => crossing.
    always_comb begin
        nmask = 4'b1111;
        case (req_size)
            2'b00:   nmask = 4'b0001;
            2'b01:   nmask = 4'b0011;
            default: nmask = 4'b1111;
        endcase
    end

    assign lane_mask = {4'b0000, nmask} << off;
    assign wd_shift  = {32'h0, write_data} << {off, 3'b000};
    assign crossing  = |lane_mask[7:4];

    // The array is read asynchronously; SECOND reads the following (wrapped) word.
    assign rd_idx       = (state_q == SECOND) ? idx2_q : idx;
    assign rd_word      = mem[rd_idx];
    assign single_raw   = rd_word >> {off, 3'b000};
    assign cross_window = {rd_word, first_q} >> {off_q, 3'b000};

    // Upper address bits alias onto the array; the high half of the window is shifted out.
    logic unused_bits;
    assign unused_bits = ^{address[ADDR_WIDTH-1:IDX+2], cross_window[63:32]};

    function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [1:0] sz,
                                        input logic uns);
        logic [31:0] r;
        case (sz)
            2'b00:   r = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   r = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Select the write port: first/only beat from live inputs, second beat from latched context.
    always_comb begin
        wr_idx  = idx;
        wr_be   = 4'b0000;
        wr_data = wd_shift[31:0];
        if (accept && req_we) begin
            wr_be = lane_mask[3:0];
        end else if (state_q == SECOND && we_q && !rst) begin
            wr_idx  = idx2_q;
            wr_be   = be2_q;
            wr_data = wd2_q;
        end
    end

    // Byte-lane writes; contents are never touched by reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Beat sequencing with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            read_data_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (accept) begin
                        if (crossing) begin
                            state_q <= SECOND;
                            idx2_q  <= idx2_d;
                            off_q   <= off;
                            size_q  <= req_size;
                            uns_q   <= req_unsigned;
                            we_q    <= req_we;
                            be2_q   <= lane_mask[7:4];
                            wd2_q   <= wd_shift[63:32];
                            first_q <= rd_word;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            read_data_q <= req_we ? 32'h0
                                                  : fmt(single_raw, req_size, req_unsigned);
                        end
                    end
                end
                SECOND: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b1;
                    read_data_q <= we_q ? 32'h0 : fmt(cross_window[31:0], size_q, uns_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
